fpga_prog_loader: RTL
=====================

# fpga_prog_loader

Bitstream loader that sits directly upstream of the `fpgav2` fabric's configuration shift chain. It accepts the configuration image as a byte stream over a valid/ready interface and serialises it LSB-first onto `prog_in`. It generates `prog_clk`/`prog_en` with the fabric's setup/high/low phasing. In verify mode it compares `prog_out` against each incoming bit, so resending an image proves the chain holds what was last loaded.

## Interface
- `NUM_BITS`, 1480, length of the fabric configuration chain in bits.
- `PHASE_CYCLES`, 1, `clk` cycles per `prog_clk` phase (setup, high, low); must be ≥1.
- `ERR_W`, 11, width of `mismatch_count`.

- `clk` input 1 — single system clock; all logic on its rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `start` input 1 — one-cycle request to begin a load; sampled only in IDLE.
- `verify` input 1 — latched with `start`; enables `prog_out` comparison.
- `s_data` input 8 — image byte; bit 0 is shifted first.
- `s_valid` input 1 — `s_data` valid.
- `s_ready` output 1 — loader accepts a byte this cycle.
- `prog_in` output 1 — serial config data to the fabric.
- `prog_clk` output 1 — config shift clock.
- `prog_en` output 1 — config shift enable.
- `prog_out` input 1 — chain tail from the fabric.
- `busy` output 1 — load in progress.
- `done` output 1 — one-cycle pulse at load completion.
- `err` output 1 — sticky; set at completion if `mismatch_count` ≠ 0; cleared by `start`.
- `mismatch_count` output `ERR_W` — verify mismatches; saturates at all-ones; cleared by `start`.

## Operation
- FSM states: IDLE, FETCH, SETUP, HIGH, LOW, DONE.
- **IDLE**
  - `start` → FETCH.
  - On the same edge: latch `verify`, clear the bit counter, `mismatch_count` and `err`.
  - `start` outside IDLE is ignored.
- **FETCH**
  - `s_ready`=1.
  - On `s_valid & s_ready`, capture the byte into the shift register; bit index within byte = 0; → SETUP.
  - Without `s_valid`, remain in FETCH indefinitely; no `prog_clk` edges occur.
- **SETUP** (`PHASE_CYCLES` cycles)
  - `prog_in` = current bit.
  - On the last SETUP cycle, if verify mode and `prog_out` ≠ current bit, increment `mismatch_count` (saturating). This sample is taken before the shift edge, so it compares against the bit about to leave the chain.
  - → HIGH.
- **HIGH** (`PHASE_CYCLES` cycles)
  - `prog_clk`=1, `prog_in` held.
  - → LOW.
- **LOW** (`PHASE_CYCLES` cycles)
  - `prog_clk`=0, `prog_in` held.
  - Then increment the global bit counter:
    - counter = `NUM_BITS` → DONE;
    - else byte exhausted (8 bits) → FETCH;
    - else → SETUP with the next bit.
- **DONE** (1 cycle)
  - `done`=1; `err` ← (`mismatch_count` ≠ 0); → IDLE.
- Bytes consumed = ceil(`NUM_BITS`/8). Unused upper bits of the final byte are ignored and are never shifted.
- `prog_en`=1 in SETUP/HIGH/LOW and in FETCH after the first byte of a load. It is 0 in IDLE, in the initial FETCH, and in DONE.
- `busy`=1 in FETCH/SETUP/HIGH/LOW; 0 in IDLE/DONE.

## Timing
- Reset values:
  - `s_ready`, `prog_in`, `prog_clk`, `prog_en`, `busy`, `done`, `err` = 0; `mismatch_count` = 0.
  - FSM in IDLE.
- Reset mid-load: the next cycle drives all outputs to their reset values and returns to IDLE. The fabric chain is left partially loaded, and a full reload is required.
- Per bit: exactly 3·`PHASE_CYCLES` cycles and exactly one `prog_clk` rising edge.
- `prog_in` changes only on entry to SETUP, never while `prog_clk`=1.
- With `s_valid` held high: `done` asserts at cycle 1 + ceil(`NUM_BITS`/8) + 3·`PHASE_CYCLES`·`NUM_BITS`, counted from the `start` cycle as 0.
- Backpressure only inserts FETCH cycles; `prog_clk` stays 0 throughout them.

## Structure
- Shared package `fpga_prog_pkg` holds:
  - FSM state encoding;
  - `FPGAV2_CFG_BITS` = 1480, used by benches and top-level instantiation.
- One sub-module, `prog_phase_timer`: a `PHASE_CYCLES` down-counter producing a phase-complete strobe. It reloads on every state change.
- Bit counter width: $clog2(`NUM_BITS`+1).

## Test plan
- **Reset:** assert `rst` 3 cycles with random inputs → all outputs 0, `s_ready`=0, no `prog_clk` edge.
- **Small load** (`NUM_BITS`=16, P=1), bytes 0xA5, 0x3C with `s_valid` always high, `start` at cycle 0:
  - `prog_in` at each rising edge = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0;
  - exactly 16 edges;
  - `done` at cycle 51.
- **Verify:**
  - After the small load, verify-load 0xA5, 0x3C → `mismatch_count`=0, `err`=0.
  - Then verify-load 0xA4, 0x3C → `mismatch_count`=1, `err`=1.
- **Backpressure:** drop `s_valid` for 5 cycles before byte 2 → `prog_clk` stays 0, `prog_en` stays 1, still exactly 16 edges, `done` 5 cycles later.
- **Abort:** `rst` after the 5th rising edge → outputs 0 next cycle. A fresh `start` then completes a full 16-bit load correctly.
- **Full size** (`NUM_BITS`=1480, P=2), 185 bytes:
  - 1480 `prog_clk` edges;
  - `done` at cycle 9066;
  - a repeated verify load reports 0 mismatches.

Source files
------------

// File: rtl/fpga_prog_pkg.sv
// Shared definitions for the fpgav2 configuration loader: FSM encoding and the
// fabric chain length used by top-level instantiations and benches.
package fpga_prog_pkg;
  localparam int FPGAV2_CFG_BITS = 1480;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    HIGH,
    LOW,
    DONE
  } state_t;
endpackage

// File: rtl/fpga_prog_loader_if.sv
// Loader-facing bundle: image byte stream in, configuration shift chain out.
// master = image source / fabric side, slave = loader.
interface fpga_prog_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       prog_in;
  logic       prog_clk;
  logic       prog_en;
  logic       prog_out;

  modport master (output s_data, s_valid, prog_out,
                  input  s_ready, prog_in, prog_clk, prog_en);
  modport slave  (input  s_data, s_valid, prog_out,
                  output s_ready, prog_in, prog_clk, prog_en);
endinterface

// File: rtl/fpga_prog_loader_phase_timer.sv
// Down-counter timing each prog_clk phase; phase_done marks the last cycle of
// the current phase. Reloads whenever the loader FSM changes state.
module prog_phase_timer #(
  parameter int PHASE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic phase_done
);
  localparam int W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || reload)  cnt <= W'(PHASE_CYCLES - 1);
    else if (cnt != '0) cnt <= cnt - W'(1);
  end

  assign phase_done = (cnt == '0);
endmodule

// File: rtl/fpga_prog_loader.sv
// Byte-stream to serial config-chain loader for the fpgav2 fabric, with optional
// compare of the chain tail against the image being shifted in.
module fpga_prog_loader
  import fpga_prog_pkg::*;
#(
  parameter int NUM_BITS     = FPGAV2_CFG_BITS,
  parameter int PHASE_CYCLES = 1,
  parameter int ERR_W        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify,
  fpga_prog_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERR_W-1:0]  mismatch_count
);
  localparam int CNT_W = $clog2(NUM_BITS + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sr;
  logic             verify_q;
  logic             phase_done;
  logic             last_bit;

  assign last_bit = (bit_cnt == CNT_W'(NUM_BITS - 1));
  // sr only moves on SETUP entry, so prog_in is stable across HIGH/LOW
  assign bus.prog_in = sr[0];

  prog_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .reload     (state_nxt != state),
    .phase_done (phase_done)
  );

  always_comb begin
    state_nxt    = state;
    bus.s_ready  = 1'b0;
    bus.prog_clk = 1'b0;
    bus.prog_en  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        bus.s_ready = 1'b1;
        busy        = 1'b1;
        // enable stays low until the first byte of the load has arrived
        bus.prog_en = (bit_cnt != '0);
        if (bus.s_valid) state_nxt = SETUP;
      end
      SETUP: begin
        busy        = 1'b1;
        bus.prog_en = 1'b1;
        if (phase_done) state_nxt = HIGH;
      end
      HIGH: begin
        busy         = 1'b1;
        bus.prog_en  = 1'b1;
        bus.prog_clk = 1'b1;
        if (phase_done) state_nxt = LOW;
      end
      LOW: begin
        busy        = 1'b1;
        bus.prog_en = 1'b1;
        if (phase_done) begin
          if (last_bit)              state_nxt = DONE;
          else if (bit_idx == 3'd7)  state_nxt = FETCH;
          else                       state_nxt = SETUP;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      bit_idx        <= '0;
      sr             <= '0;
      verify_q       <= 1'b0;
      mismatch_count <= '0;
      err            <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          verify_q       <= verify;
          bit_cnt        <= '0;
          mismatch_count <= '0;
          err            <= 1'b0;
        end
        FETCH: if (bus.s_valid) begin
          sr      <= bus.s_data;
          bit_idx <= '0;
        end
        // sampled before the shift edge: prog_out is the bit about to leave
        SETUP: if (phase_done && verify_q && (bus.prog_out != sr[0]) &&
                   (mismatch_count != '1))
          mismatch_count <= mismatch_count + ERR_W'(1);
        LOW: if (phase_done) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          bit_idx <= bit_idx + 3'd1;
          if (!last_bit && (bit_idx != 3'd7)) sr <= {1'b0, sr[7:1]};
        end
        DONE: err <= (mismatch_count != '0);
        default: ;
      endcase
    end
  end
endmodule
